uart_tx: RTL and testbench

Serial UART transmitter for the peripheral bus: the transmit end of the same 8N1 link the receiver samples on UART_RX. A byte written by the peripheral register logic is framed (start bit, 8 data bits LSB first, stop bit) and shifted out on UART_TX at a fixed baud rate. A one-byte holding register lets software queue the next byte while the current frame is still on the line. Status and done/overrun flags feed the UART control register and the interrupt logic.

---
 rtl/uart_tx.sv | 128 ++++++++++++
 tb/tb_uart_tx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with one-byte holding register and overrun flag
module uart_tx #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_en,
    input  logic [7:0] tx_data,
    input  logic       ovr_clr,
    output logic       UART_TX,
    output logic       tx_busy,
    output logic       tx_full,
    output logic       tx_done,
    output logic       tx_ovr
);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
    logic [7:0]    hold_reg;

    logic       baud_last;
    logic [2:0] next_idx;
    logic       consume;

    assign baud_last = (baud_cnt == BAUD_LAST);
    assign next_idx  = bit_idx + 3'd1;
    // The holding byte leaves this cycle, so a coincident write refills it instead of overrunning.
    assign consume   = tx_full && ((state == IDLE) || ((state == STOP) && baud_last));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'h00;
            hold_reg  <= 8'h00;
            UART_TX   <= 1'b1;
            tx_busy   <= 1'b0;
            tx_full   <= 1'b0;
            tx_done   <= 1'b0;
            tx_ovr    <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (ovr_clr)
                tx_ovr <= 1'b0;

            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    bit_idx  <= 3'd0;
                    if (tx_full) begin
                        shift_reg <= hold_reg;
                        tx_full   <= 1'b0;
                        state     <= START;
                        UART_TX   <= 1'b0;
                        tx_busy   <= 1'b1;
                    end else if (tx_en) begin
                        shift_reg <= tx_data;
                        state     <= START;
                        UART_TX   <= 1'b0;
                        tx_busy   <= 1'b1;
                    end
                end
                START: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        bit_idx  <= 3'd0;
                        state    <= DATA;
                        UART_TX  <= shift_reg[0];
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state   <= STOP;
                            UART_TX <= 1'b1;
                        end else begin
                            bit_idx <= next_idx;
                            UART_TX <= shift_reg[next_idx];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                STOP: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (tx_full) begin
                            shift_reg <= hold_reg;
                            tx_full   <= 1'b0;
                            state     <= START;
                            UART_TX   <= 1'b0;
                        end else begin
                            state   <= IDLE;
                            tx_busy <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                        // Registered pulse lands on the final stop-bit cycle.
                        if (baud_cnt == BAUD_PRE)
                            tx_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // Later assignments override the tx_full clear above when a refill coincides.
            if (tx_en && ((state != IDLE) || tx_full)) begin
                if (!tx_full || consume) begin
                    hold_reg <= tx_data;
                    tx_full  <= 1'b1;
                end else begin
                    tx_ovr <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - randomized and directed bench for uart_tx against a frame-position model
module tb_uart_tx;
    localparam int C  = 4;
    localparam int BC = 5208;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx_en = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       ovr_clr = 1'b0;
    logic       UART_TX, tx_busy, tx_full, tx_done, tx_ovr;

    logic       b_rst = 1'b1;
    logic       b_en = 1'b0;
    logic [7:0] b_data = 8'h00;
    logic       b_clr = 1'b0;
    logic       b_line, b_busy, b_full, b_done, b_ovr;

    int vectors = 0;
    int miscompares = 0;
    bit big_done = 1'b0;

    uart_tx #(.CLKS_PER_BIT(C)) dut (
        .clk(clk), .reset(reset), .tx_en(tx_en), .tx_data(tx_data), .ovr_clr(ovr_clr),
        .UART_TX(UART_TX), .tx_busy(tx_busy), .tx_full(tx_full), .tx_done(tx_done), .tx_ovr(tx_ovr)
    );

    uart_tx u_big (
        .clk(clk), .reset(b_rst), .tx_en(b_en), .tx_data(b_data), .ovr_clr(b_clr),
        .UART_TX(b_line), .tx_busy(b_busy), .tx_full(b_full), .tx_done(b_done), .tx_ovr(b_ovr)
    );

    always #5 clk = ~clk;

    // Model: a frame is just a position 0..10C-1; line value follows from position / C.
    bit       m_act, m_hv, m_ovr;
    int       m_pos;
    bit [7:0] m_cur, m_hold;

    always @(posedge clk or posedge reset) begin
        bit was_act, ovr_set;
        if (reset) begin
            m_act = 0; m_hv = 0; m_ovr = 0; m_pos = 0;
        end else begin
            was_act = m_act;
            ovr_set = 0;
            if (!m_act) begin
                if (m_hv) begin
                    m_cur = m_hold; m_hv = 0; m_act = 1; m_pos = 0;
                end else if (tx_en) begin
                    m_cur = tx_data; m_act = 1; m_pos = 0;
                end
            end else if (m_pos == 10*C - 1) begin
                if (m_hv) begin
                    m_cur = m_hold; m_hv = 0; m_pos = 0;
                end else begin
                    m_act = 0;
                end
            end else begin
                m_pos++;
            end
            if (was_act && tx_en) begin
                if (!m_hv) begin
                    m_hold = tx_data; m_hv = 1;
                end else begin
                    ovr_set = 1;
                end
            end
            if (ovr_clr) m_ovr = 0;
            if (ovr_set) m_ovr = 1;
        end
    end

    always @(negedge clk) begin
        int  k;
        bit  e_line;
        logic [4:0] got, expv;
        if (!reset) begin
            e_line = 1;
            if (m_act) begin
                k = m_pos / C;
                if (k == 0) e_line = 0;
                else if (k <= 8) e_line = m_cur[k-1];
                else e_line = 1;
            end
            got  = {UART_TX, tx_busy, tx_full, tx_done, tx_ovr};
            expv = {e_line, m_act, m_hv, (m_act && m_pos == 10*C - 1), m_ovr};
            vectors++;
            if (got !== expv) begin
                miscompares++;
                $display("FAIL cycle_cmp t=%0t {line,busy,full,done,ovr} got %b expected %b", $time, got, expv);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    bit       sched_en  [0:255];
    bit       sched_clr [0:255];
    bit [7:0] sched_data[0:255];
    bit       lg_line[0:255], lg_busy[0:255], lg_full[0:255], lg_done[0:255], lg_ovr[0:255];

    task automatic cyc(input bit en, input bit [7:0] d, input bit clr);
        @(negedge clk);
        tx_en = en; tx_data = d; ovr_clr = clr;
    endtask

    task automatic run(input int n);
        for (int i = 0; i <= n; i++) begin
            cyc(sched_en[i], sched_data[i], sched_clr[i]);
            lg_line[i] = UART_TX; lg_busy[i] = tx_busy; lg_full[i] = tx_full;
            lg_done[i] = tx_done; lg_ovr[i] = tx_ovr;
        end
        for (int i = 0; i < 256; i++) begin
            sched_en[i] = 0; sched_clr[i] = 0; sched_data[i] = 0;
        end
    endtask

    task automatic put(input int at, input bit [7:0] d);
        sched_en[at] = 1; sched_data[at] = d;
    endtask

    task automatic chk_frame(input string name, input bit [9:0] pat, input int base);
        int same;
        for (int k = 0; k < 10; k++) begin
            same = 0;
            for (int j = 1; j <= C; j++)
                if (lg_line[base + k*C + j] == pat[k]) same++;
            check($sformatf("%s_cell%0d", name, k), same, C);
        end
    endtask

    function automatic int done_count(input int n);
        int c = 0;
        for (int i = 0; i <= n; i++) if (lg_done[i]) c++;
        return c;
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) begin
            sched_en[i] = 0; sched_clr[i] = 0; sched_data[i] = 0;
        end
        @(negedge clk);
        check("rst_line", UART_TX, 1);
        check("rst_flags", {tx_busy, tx_full, tx_done, tx_ovr}, 0);
        reset = 0;

        // single byte 0x96
        put(0, 8'h96);
        run(45);
        chk_frame("b96", 10'b1100101100, 0);
        check("b96_done40", lg_done[40], 1);
        check("b96_done_cnt", done_count(45), 1);
        check("b96_busy1", lg_busy[1], 1);
        check("b96_busy41", lg_busy[41], 0);

        // queued pair
        put(0, 8'hA7); put(5, 8'hFF);
        run(85);
        check("pair_full40", lg_full[40], 1);
        check("pair_full41", lg_full[41], 0);
        check("pair_start41", lg_line[41], 0);
        check("pair_done80", lg_done[40] && lg_done[80], 1);
        check("pair_done_cnt", done_count(85), 2);
        check("pair_busy81", lg_busy[81], 0);

        // overrun
        put(0, 8'h11); put(3, 8'h22); put(6, 8'h33); sched_clr[90] = 1;
        run(95);
        check("ovr_set7", lg_ovr[7], 1);
        check("ovr_held90", lg_ovr[90], 1);
        check("ovr_clr91", lg_ovr[91], 0);
        check("ovr_frames", done_count(95), 2);
        chk_frame("ovr_f2", 10'b1001000100, 40);

        // write on the exact last stop cycle while full
        put(0, 8'h11); put(3, 8'h22); put(40, 8'h55);
        run(125);
        check("edge_frames", done_count(125), 3);
        check("edge_ovr", lg_ovr[121], 0);
        chk_frame("edge_f3", 10'b1010101010, 80);

        // async reset mid-frame
        put(0, 8'h00); put(2, 8'h77);
        run(18);
        check("pre_rst_line", UART_TX, 0);
        #2 reset = 1;
        #1;
        check("async_line", UART_TX, 1);
        check("async_flags", {tx_busy, tx_full, tx_done, tx_ovr}, 0);
        @(negedge clk);
        reset = 0;
        put(0, 8'h3C);
        run(42);
        chk_frame("b3c", 10'b1001111000, 0);
        check("b3c_done", done_count(42), 1);

        // randomized traffic, checked every cycle by the model compare process
        for (int i = 0; i < 3000; i++)
            cyc(($urandom % 16) == 0, 8'($urandom), ($urandom % 40) == 0);
        cyc(0, 0, 0);

        for (int i = 0; i < 60000 && !big_done; i++) @(negedge clk);
        check("big_finished", big_done, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // default-parameter instance: one 0x41 frame
    initial begin
        int k, errs, dcnt, dpos;
        bit e;
        bit [7:0] b_byte;
        b_byte = 8'h41;
        errs = 0; dcnt = 0; dpos = 0;
        @(negedge clk);
        b_rst = 0;
        @(negedge clk);
        b_en = 1; b_data = b_byte;
        for (int n = 1; n <= 10*BC + 1; n++) begin
            @(negedge clk);
            b_en = 0;
            k = (n - 1) / BC;
            e = (k == 0) ? 1'b0 : (k <= 8) ? b_byte[k-1] : 1'b1;
            if (n <= 10*BC && b_line !== e) errs++;
            if (b_done) begin dcnt++; dpos = n; end
            if (n == 1) check("big_busy_rise", b_busy, 1);
            if (n == 10*BC + 1) begin
                check("big_idle_line", b_line, 1);
                check("big_busy_fall", b_busy, 0);
            end
        end
        check("big_cells", errs, 0);
        check("big_done_cnt", dcnt, 1);
        check("big_done_pos", dpos, 52080);
        big_done = 1;
    end
endmodule
